// File: rtl/drive_arbiter_if.sv
// Drive arbiter bus: mode-select flags, the two command sources and the
// arbitrated wheel speeds and status returned to the rest of the system.
interface drive_arbiter_if;
    logic              manual_on;
    logic              auto_on;
    logic              man_valid;
    logic signed [7:0] man_left;
    logic signed [7:0] man_right;
    logic              auto_valid;
    logic signed [7:0] auto_left;
    logic signed [7:0] auto_right;
    logic signed [7:0] left_speed;
    logic signed [7:0] right_speed;
    logic [1:0]        active_src;
    logic              timeout;
    logic              switching;

    // Mode selection and command sources
    modport master (
        output manual_on, auto_on,
        output man_valid, man_left, man_right,
        output auto_valid, auto_left, auto_right,
        input  left_speed, right_speed, active_src, timeout, switching
    );

    // Arbiter side
    modport slave (
        input  manual_on, auto_on,
        input  man_valid, man_left, man_right,
        input  auto_valid, auto_left, auto_right,
        output left_speed, right_speed, active_src, timeout, switching
    );
endinterface

// File: rtl/drive_arbiter.sv
// Drive arbiter: picks the manual or autonomous speed source, forces a brake
// dwell on every mode change, runs a per-source command watchdog and
// slew-limits both wheel speeds toward their targets.
module drive_arbiter #(
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int SWITCH_CYCLES  = 2_500_000,
    parameter int RAMP_DIV       = 50_000,
    parameter int STEP           = 4
) (
    input logic            clk,
    input logic            rst_n,
    drive_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ST_STOP, ST_MANUAL, ST_AUTO, ST_SWITCH} state_t;

    localparam logic [1:0]        SRC_NONE   = 2'b00;
    localparam logic [1:0]        SRC_MAN    = 2'b01;
    localparam logic [1:0]        SRC_AUTO   = 2'b10;
    localparam logic [1:0]        SRC_SWITCH = 2'b11;
    localparam logic [31:0]       TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]       SW_LAST    = 32'(SWITCH_CYCLES - 1);
    localparam logic [31:0]       DIV_LAST   = 32'(RAMP_DIV - 1);
    localparam logic signed [8:0] STEP_W     = 9'(STEP);
    localparam logic signed [7:0] STEP_B     = 8'(STEP);

    state_t            state_q;
    logic [31:0]       sw_cnt_q;
    logic [31:0]       wd_cnt_q;
    logic [31:0]       div_cnt_q;
    logic signed [7:0] tgt_l_q, tgt_r_q;
    logic signed [7:0] left_q, right_q;
    logic signed [7:0] left_d, right_d;
    logic [1:0]        src_q;
    logic              timeout_q;
    logic              switching_q;

    logic              req_man, req_auto;
    logic              mode_lost;
    logic              sel_valid;
    logic signed [7:0] sel_left, sel_right;
    logic              ramp_pulse;
    logic              outs_zero;

    // Move one ramp step toward the target; the 9-bit difference cannot wrap
    // and the final partial step lands exactly on the target.
    function automatic logic signed [7:0] ramp_step(input logic signed [7:0] cur,
                                                    input logic signed [7:0] tgt);
        logic signed [8:0] diff;
        diff = $signed({tgt[7], tgt}) - $signed({cur[7], cur});
        if (diff > STEP_W)
            return cur + STEP_B;
        else if (diff < -STEP_W)
            return cur - STEP_B;
        else
            return tgt;
    endfunction

    assign req_man    = bus.manual_on & ~bus.auto_on;
    assign req_auto   = bus.auto_on & ~bus.manual_on;
    assign ramp_pulse = (div_cnt_q == DIV_LAST);
    assign outs_zero  = (left_q == 8'sd0) && (right_q == 8'sd0);

    // Route the currently selected source; the other source is simply dropped
    always_comb begin
        mode_lost = 1'b0;
        sel_valid = 1'b0;
        sel_left  = '0;
        sel_right = '0;
        if (state_q == ST_MANUAL) begin
            mode_lost = ~req_man;
            sel_valid = bus.man_valid;
            sel_left  = bus.man_left;
            sel_right = bus.man_right;
        end else if (state_q == ST_AUTO) begin
            mode_lost = ~req_auto;
            sel_valid = bus.auto_valid;
            sel_left  = bus.auto_left;
            sel_right = bus.auto_right;
        end
    end

    // Mode FSM with target latch, watchdog and brake-dwell counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_STOP;
            sw_cnt_q    <= '0;
            wd_cnt_q    <= '0;
            tgt_l_q     <= '0;
            tgt_r_q     <= '0;
            src_q       <= SRC_NONE;
            timeout_q   <= 1'b0;
            switching_q <= 1'b0;
        end else begin
            case (state_q)
                ST_STOP: begin
                    tgt_l_q   <= '0;
                    tgt_r_q   <= '0;
                    timeout_q <= 1'b0;
                    if (req_man || req_auto) begin
                        state_q     <= ST_SWITCH;
                        sw_cnt_q    <= '0;
                        src_q       <= SRC_SWITCH;
                        switching_q <= 1'b1;
                    end
                end
                ST_MANUAL, ST_AUTO: begin
                    if (mode_lost) begin
                        state_q     <= ST_SWITCH;
                        sw_cnt_q    <= '0;
                        tgt_l_q     <= '0;
                        tgt_r_q     <= '0;
                        timeout_q   <= 1'b0;
                        src_q       <= SRC_SWITCH;
                        switching_q <= 1'b1;
                    end else if (sel_valid) begin
                        tgt_l_q   <= sel_left;
                        tgt_r_q   <= sel_right;
                        wd_cnt_q  <= '0;
                        timeout_q <= 1'b0;
                    end else begin
                        // Counter saturates once the source is declared dead
                        if (wd_cnt_q <= TO_LAST)
                            wd_cnt_q <= wd_cnt_q + 32'd1;
                        if (wd_cnt_q >= TO_LAST) begin
                            timeout_q <= 1'b1;
                            tgt_l_q   <= '0;
                            tgt_r_q   <= '0;
                        end
                    end
                end
                default: begin
                    // Brake dwell: destination is whatever is requested at exit
                    tgt_l_q <= '0;
                    tgt_r_q <= '0;
                    if (sw_cnt_q < SW_LAST)
                        sw_cnt_q <= sw_cnt_q + 32'd1;
                    if ((sw_cnt_q >= SW_LAST) && outs_zero) begin
                        switching_q <= 1'b0;
                        wd_cnt_q    <= '0;
                        if (req_man) begin
                            state_q <= ST_MANUAL;
                            src_q   <= SRC_MAN;
                        end else if (req_auto) begin
                            state_q <= ST_AUTO;
                            src_q   <= SRC_AUTO;
                        end else begin
                            state_q <= ST_STOP;
                            src_q   <= SRC_NONE;
                        end
                    end
                end
            endcase
        end
    end

    // Next output values: step toward the targets only on divider pulses
    always_comb begin
        left_d  = left_q;
        right_d = right_q;
        if (ramp_pulse) begin
            left_d  = ramp_step(left_q, tgt_l_q);
            right_d = ramp_step(right_q, tgt_r_q);
        end
    end

    // Free-running ramp divider and registered speed outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            left_q    <= '0;
            right_q   <= '0;
        end else begin
            div_cnt_q <= ramp_pulse ? 32'd0 : div_cnt_q + 32'd1;
            left_q    <= left_d;
            right_q   <= right_d;
        end
    end

    assign bus.left_speed  = left_q;
    assign bus.right_speed = right_q;
    assign bus.active_src  = src_q;
    assign bus.timeout     = timeout_q;
    assign bus.switching   = switching_q;
endmodule

// File: doc/drive_arbiter.md
Name: drive_arbiter

Overview:
- Owns the motor speed outputs and shares them between two requesters: the Arduino manual channel and the autonomous navigation channel.
- Selects the requester from the mode-select flags `manual_on` and `auto_on`.
- Inserts a forced brake interval on every mode change.
- Enforces a per-source command watchdog.
- Slew-limits both wheel speeds so the motor driver never sees step changes.
- Sits between mode selection / command sources and the PWM generators.

Parameters:
- TIMEOUT_CYCLES, 5_000_000: cycles without a valid from the selected source before it is considered dead (100 ms at 50 MHz).
- SWITCH_CYCLES, 2_500_000: minimum brake dwell on a mode change.
- RAMP_DIV, 50_000: cycles between ramp steps.
- STEP, 4: maximum change of each speed per ramp step (unsigned, 1..127).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- manual_on  in  1  manual mode selected
- auto_on  in  1  autonomous mode selected
- man_valid  in  1  single-cycle strobe; man_left/man_right valid
- man_left  in  8  signed left wheel speed request, manual
- man_right  in  8  signed right wheel speed request, manual
- auto_valid  in  1  single-cycle strobe; auto_left/auto_right valid
- auto_left  in  8  signed left wheel speed request, auto
- auto_right  in  8  signed right wheel speed request, auto
- left_speed  out  8  signed left speed to PWM stage
- right_speed  out  8  signed right speed to PWM stage
- active_src  out  2  00 none, 01 manual, 10 auto, 11 switching
- timeout  out  1  selected source watchdog expired
- switching  out  1  high in SWITCH state

Behaviour:
- Reset (async assert, sync release):
  - state = STOP; targets, left_speed, right_speed = 0.
  - active_src = 00; timeout = 0; switching = 0; all counters = 0.
- Requested mode:
  - MANUAL if manual_on & !auto_on; AUTO if auto_on & !manual_on.
  - Otherwise (neither or both asserted) NONE.
- States:
  - STOP: targets = 0; active_src = 00. Requested MANUAL/AUTO -> SWITCH with dest latched.
  - MANUAL: target updated on man_valid; auto_valid ignored. Requested mode != MANUAL -> SWITCH (dest = requested, NONE allowed).
  - AUTO: mirror of MANUAL using auto_valid.
  - SWITCH:
    - Targets forced 0; switch counter increments each cycle.
    - Exit when counter >= SWITCH_CYCLES-1 AND left_speed == 0 AND right_speed == 0.
    - Exit destination is the currently requested mode (re-evaluated at exit). NONE -> STOP; else that mode.
    - A request change during SWITCH does not restart the counter.
    - On entry to MANUAL/AUTO: targets = 0, watchdog cleared; a fresh valid is required before motion.
- Target latch:
  - In MANUAL/AUTO, a valid strobe from the selected source loads both targets on the next edge.
  - Valids from the other source are dropped (no buffering).
- Watchdog:
  - Counter clears on a selected-source valid and on state entry; otherwise increments in MANUAL/AUTO.
  - Reaching TIMEOUT_CYCLES sets timeout = 1 and forces targets to 0.
  - The next selected valid clears timeout and loads the targets in the same edge.
  - timeout = 0 in STOP and SWITCH.
- Ramp:
  - Divider pulses every RAMP_DIV cycles, free-running from reset.
  - On a pulse, each output moves toward its target by min(STEP, |target-output|).
  - Difference computed in 9-bit signed; no overflow across -128..127.
  - The output never overshoots the target.
  - Sign reversal passes through 0 with no special dwell.
- Output timing: left_speed and right_speed are registered; they change only on ramp pulses.
- Reset mid-ramp or mid-SWITCH: outputs go to 0 immediately (async).

Test Plan (overrides: TIMEOUT_CYCLES=100, SWITCH_CYCLES=20, RAMP_DIV=4, STEP=4):
- Startup: release reset with manual_on=1 -> active_src=11 for >=20 cycles, then 01; outputs stay 0 until a man_valid arrives.
- Ramp: in MANUAL, man_valid with left=10, right=-6 -> left 4, 8, 10 and right -4, -6 on successive ramp pulses (every 4 cycles); no overshoot.
- Isolation: in MANUAL, auto_valid with left=50 -> no change to targets or outputs.
- Mode change: left=40 in MANUAL, then auto_on=1/manual_on=0 -> switching=1; left ramps to 0 (10 pulses, 40 cycles); exit to AUTO only after both counter >=19 and output 0; active_src=10.
- Watchdog: in AUTO, no auto_valid for 100 cycles -> timeout=1 and outputs ramp to 0. A following auto_valid with left=8 -> timeout=0 and left ramps to 8.
- Edge cases:
  - Both manual_on and auto_on high -> SWITCH, then STOP, outputs 0.
  - Reset asserted mid-SWITCH with left=-20 -> left=0 and active_src=00 asynchronously.
